pipe_mem_stage: RTL and testbench
=================================

PIPE_MEM_STAGE -- requirements
Module: pipe_mem_stage

Interface
REQ-001 Parameter ACK_TIMEOUT, default 255: cycles in WAIT without in_dmem_ack before the access is abandoned; legal range 1..255.
REQ-002 in_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 in_rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  EX/MEM register holds a live instruction.
REQ-005 in_dmem_ena, in_dmem_wena  input  1 each  memory access / store.
REQ-006 in_dmem_type  input  2  access size: 00 word, 01 half, 10 byte, 11 reserved (treated as word).
REQ-007 in_dmem_sign  input  1  sign-extend loads.
REQ-008 in_rt_data, in_alu_result  input  32 each  store data; address or ALU result.
REQ-009 in_rd_waddr  input  5; in_rd_sel, in_rd_wena  input  1 each; in_rd_sel=1 selects load data for writeback.
REQ-010 out_dmem_req  output  1; out_dmem_we  output  1; out_dmem_be  output  4; out_dmem_addr  output  32; out_dmem_wdata  output  32.
REQ-011 in_dmem_ack  input  1; in_dmem_rdata  input  32.
REQ-012 out_stall  output  1  freezes upstream stages and EX/MEM register.
REQ-013 out_wb_valid, out_rd_wena  output  1 each; out_rd_waddr  output  5; out_wb_data  output  32 (MEM/WB register).
REQ-014 out_bus_err  output  1  one-cycle pulse on timeout or trapped misalignment.

Function
REQ-015 FSM states IDLE, WAIT; accepts in_valid only in IDLE.
REQ-016 Non-memory op in IDLE: MEM/WB outputs load next edge (latency 1), out_wb_data=in_alu_result, out_stall=0.
REQ-017 Memory op in IDLE: next edge enters WAIT, registers out_dmem_req=1, out_dmem_addr={alu[31:2],2'b00}, out_dmem_we=in_dmem_wena, byte enables from size and alu[1:0] (byte 0001<<a, half 0011<<a[1], word 1111).
REQ-018 Store data replicated across lanes: byte x4, half x2, word as-is.
REQ-019 out_stall asserted combinationally from memory-op acceptance cycle through WAIT, deasserted in the cycle in_dmem_ack is sampled high.
REQ-020 Request signals held stable in WAIT until ack; req drops the edge after ack.
REQ-021 Load: lane selected by latched address low bits, zero/sign-extended per in_dmem_sign; out_wb_data=extended data if rd_sel=1, else latched ALU result.
REQ-022 Ack edge: MEM/WB loaded, out_wb_valid=1, FSM to IDLE; back-to-back memory op accepted the following cycle.
REQ-023 Timeout counter (8 bits) clears on WAIT entry, increments per WAIT cycle; reaching ACK_TIMEOUT drops req, pulses out_bus_err, writes MEM/WB with out_rd_wena=0, returns IDLE.
REQ-024 Ack arriving in the same cycle the counter reaches ACK_TIMEOUT: ack wins, no error.
REQ-025 Idle cycles without in_valid: out_wb_valid=0, out_rd_wena=0.

Reset
REQ-026 in_rst high at a clock edge: FSM IDLE, counter 0, all outputs 0, including mid-WAIT (request abandoned, no writeback).

Configuration
REQ-027 Macro MEM_MISALIGN_TRAP_EN defined: half with alu[0]=1 or word with alu[1:0]!=0 issues no request, pulses out_bus_err, writes MEM/WB with out_rd_wena=0, latency 1.
REQ-028 Macro undefined: misaligned addresses issue normally with low bits truncated per REQ-017; out_bus_err only on timeout.

Structure
REQ-029 Shared package holds access-size encodings, FSM state typedef, lane-enable constants.
REQ-030 Sub-module pipe_mem_align: combinational byte-enable, store replication, load extraction/extension.

Verification
REQ-031 sb rt=0x000000AB, addr 0x1003, ack after 2 cycles -> be=1000, wdata=0xABABABAB, stall 3 cycles, no writeback.
REQ-032 lb sign, addr 0x2001, rdata 0x0000F000 -> out_wb_data=0xFFFFFFF0, rd_wena=1.
REQ-033 lhu addr 0x2002, rdata 0x8001FFFF -> out_wb_data=0x00008001.
REQ-034 No ack, ACK_TIMEOUT=4 -> req dropped after 4 WAIT cycles, one err pulse, rd_wena=0.
REQ-035 lw addr 0x3002 with macro -> no req, err pulse; without macro -> req to 0x3000, be=1111.
REQ-036 Reset asserted mid-WAIT -> next edge req=0, stall=0, all outputs 0; later ack ignored.

Source files
------------

// File: rtl/pipe_mem_stage_pkg.sv
// ============================================================================
//  Module      : pipe_mem_stage_pkg
//  Description : Shared encodings for the MEM pipeline stage: access sizes,
//                FSM state type, lane-enable patterns, misalignment helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_mem_stage_pkg;

    // Access-size encodings carried on in_dmem_type
    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;   // behaves as a word access

    // Stage controller states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_t;

    // Lane-enable patterns before shifting to the addressed lane
    localparam logic [3:0] LANE_BYTE = 4'b0001;
    localparam logic [3:0] LANE_HALF = 4'b0011;
    localparam logic [3:0] LANE_WORD = 4'b1111;

    // A half access needs addr[0]=0; word (and reserved) needs addr[1:0]=0
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] lo);
        logic r;
        case (size)
            SIZE_BYTE: r = 1'b0;
            SIZE_HALF: r = lo[0];
            default:   r = (lo != 2'b00);
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_mem_stage_align.sv
// ============================================================================
//  Module      : pipe_mem_align
//  Description : Combinational lane logic: byte enables, store-data lane
//                replication and load-data extraction with zero/sign extend.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_mem_align
    import pipe_mem_stage_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        sign_i,
    input  logic [31:0] st_data_i,
    input  logic [31:0] ld_data_i,
    output logic [3:0]  be_o,
    output logic [31:0] st_data_o,
    output logic [31:0] ld_data_o
);

    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;

    // Byte enables and store replication; low address bits below the access
    // size are simply ignored (truncated) here
    always_comb begin
        be_o      = LANE_WORD;
        st_data_o = st_data_i;
        case (size_i)
            SIZE_BYTE: begin
                be_o      = LANE_BYTE << addr_lo_i;
                st_data_o = {4{st_data_i[7:0]}};
            end
            SIZE_HALF: begin
                be_o      = LANE_HALF << {addr_lo_i[1], 1'b0};
                st_data_o = {2{st_data_i[15:0]}};
            end
            default: begin
                be_o      = LANE_WORD;
                st_data_o = st_data_i;
            end
        endcase
    end

    // Lane select and extension of returned load data
    always_comb begin
        case (addr_lo_i)
            2'd0:    w_ld_byte = ld_data_i[7:0];
            2'd1:    w_ld_byte = ld_data_i[15:8];
            2'd2:    w_ld_byte = ld_data_i[23:16];
            default: w_ld_byte = ld_data_i[31:24];
        endcase
        w_ld_half = addr_lo_i[1] ? ld_data_i[31:16] : ld_data_i[15:0];
        case (size_i)
            SIZE_BYTE: ld_data_o = sign_i ? {{24{w_ld_byte[7]}}, w_ld_byte}
                                          : {24'd0, w_ld_byte};
            SIZE_HALF: ld_data_o = sign_i ? {{16{w_ld_half[15]}}, w_ld_half}
                                          : {16'd0, w_ld_half};
            default:   ld_data_o = ld_data_i;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/pipe_mem_stage.sv
// ============================================================================
//  Module      : pipe_mem_stage
//  Description : MEM pipeline stage. Issues a single outstanding data-memory
//                request, stalls upstream until ack or timeout, and loads the
//                MEM/WB register. Optional build macro MEM_MISALIGN_TRAP_EN
//                traps misaligned half/word accesses instead of issuing them.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_mem_stage
    import pipe_mem_stage_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        in_clk,
    input  logic        in_rst,
    input  logic        in_valid,
    input  logic        in_dmem_ena,
    input  logic        in_dmem_wena,
    input  logic [1:0]  in_dmem_type,
    input  logic        in_dmem_sign,
    input  logic [31:0] in_rt_data,
    input  logic [31:0] in_alu_result,
    input  logic [4:0]  in_rd_waddr,
    input  logic        in_rd_sel,
    input  logic        in_rd_wena,
    output logic        out_dmem_req,
    output logic        out_dmem_we,
    output logic [3:0]  out_dmem_be,
    output logic [31:0] out_dmem_addr,
    output logic [31:0] out_dmem_wdata,
    input  logic        in_dmem_ack,
    input  logic [31:0] in_dmem_rdata,
    output logic        out_stall,
    output logic        out_wb_valid,
    output logic        out_rd_wena,
    output logic [4:0]  out_rd_waddr,
    output logic [31:0] out_wb_data,
    output logic        out_bus_err
);

    localparam logic [7:0] TIMEOUT_LIM = 8'(ACK_TIMEOUT);

    mem_state_t  state_q;
    logic [7:0]  cnt_q;

    // Request outputs
    logic        req_q, we_q;
    logic [3:0]  be_q;
    logic [31:0] addr_q, wdata_q;

    // MEM/WB register
    logic        wb_valid_q, rd_wena_q, bus_err_q;
    logic [4:0]  rd_waddr_q;
    logic [31:0] wb_data_q;

    // Instruction context latched on acceptance, used at completion
    logic [1:0]  type_q, alo_q;
    logic        sign_q, rd_sel_q, lrd_wena_q;
    logic [4:0]  lrd_waddr_q;
    logic [31:0] alu_q;

    logic [1:0]  w_size, w_lo;
    logic [3:0]  w_be;
    logic [31:0] w_st_data, w_ld_data;
    logic        w_trap, w_accept, w_timeout;
    logic [7:0]  w_cnt_inc;

    // In IDLE the aligner works on the incoming instruction (store side);
    // in WAIT it works on the latched context (load side)
    assign w_size = (state_q == ST_IDLE) ? in_dmem_type       : type_q;
    assign w_lo   = (state_q == ST_IDLE) ? in_alu_result[1:0] : alo_q;

    pipe_mem_align u_align (
        .size_i    (w_size),
        .addr_lo_i (w_lo),
        .sign_i    (sign_q),
        .st_data_i (in_rt_data),
        .ld_data_i (in_dmem_rdata),
        .be_o      (w_be),
        .st_data_o (w_st_data),
        .ld_data_o (w_ld_data)
    );

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_trap = in_dmem_ena & is_misaligned(in_dmem_type, in_alu_result[1:0]);
`else
    assign w_trap = 1'b0;
`endif

    assign w_accept  = in_valid & in_dmem_ena & ~w_trap;
    assign w_cnt_inc = cnt_q + 8'd1;
    assign w_timeout = (w_cnt_inc == TIMEOUT_LIM);

    // Stall covers the acceptance cycle and WAIT, released in the cycle the
    // access completes (ack or timeout) so upstream advances on that edge
    assign out_stall = (state_q == ST_IDLE) ? w_accept
                                            : ~(in_dmem_ack | w_timeout);

    // Stage controller: request issue, completion, timeout and MEM/WB load
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            be_q        <= 4'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            wb_valid_q  <= 1'b0;
            rd_wena_q   <= 1'b0;
            rd_waddr_q  <= 5'd0;
            wb_data_q   <= 32'd0;
            bus_err_q   <= 1'b0;
            type_q      <= 2'd0;
            alo_q       <= 2'd0;
            sign_q      <= 1'b0;
            rd_sel_q    <= 1'b0;
            lrd_wena_q  <= 1'b0;
            lrd_waddr_q <= 5'd0;
            alu_q       <= 32'd0;
        end else begin
            bus_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (w_accept) begin
                        state_q     <= ST_WAIT;
                        cnt_q       <= 8'd0;
                        req_q       <= 1'b1;
                        we_q        <= in_dmem_wena;
                        be_q        <= w_be;
                        addr_q      <= {in_alu_result[31:2], 2'b00};
                        wdata_q     <= w_st_data;
                        type_q      <= in_dmem_type;
                        alo_q       <= in_alu_result[1:0];
                        sign_q      <= in_dmem_sign;
                        rd_sel_q    <= in_rd_sel;
                        lrd_wena_q  <= in_rd_wena;
                        lrd_waddr_q <= in_rd_waddr;
                        alu_q       <= in_alu_result;
                        wb_valid_q  <= 1'b0;
                        rd_wena_q   <= 1'b0;
                    end else if (in_valid) begin
                        // ALU op, or a trapped misaligned access
                        wb_valid_q  <= 1'b1;
                        rd_wena_q   <= in_rd_wena & ~w_trap;
                        rd_waddr_q  <= in_rd_waddr;
                        wb_data_q   <= in_alu_result;
                        bus_err_q   <= w_trap;
                    end else begin
                        wb_valid_q  <= 1'b0;
                        rd_wena_q   <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (in_dmem_ack || w_timeout) begin
                        // Ack takes priority over a coincident timeout
                        state_q    <= ST_IDLE;
                        req_q      <= 1'b0;
                        we_q       <= 1'b0;
                        be_q       <= 4'd0;
                        wb_valid_q <= 1'b1;
                        rd_waddr_q <= lrd_waddr_q;
                        rd_wena_q  <= in_dmem_ack & lrd_wena_q;
                        bus_err_q  <= ~in_dmem_ack;
                        wb_data_q  <= (in_dmem_ack && rd_sel_q) ? w_ld_data : alu_q;
                    end else begin
                        cnt_q      <= w_cnt_inc;
                        wb_valid_q <= 1'b0;
                        rd_wena_q  <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_dmem_req   = req_q;
    assign out_dmem_we    = we_q;
    assign out_dmem_be    = be_q;
    assign out_dmem_addr  = addr_q;
    assign out_dmem_wdata = wdata_q;
    assign out_wb_valid   = wb_valid_q;
    assign out_rd_wena    = rd_wena_q;
    assign out_rd_waddr   = rd_waddr_q;
    assign out_wb_data    = wb_data_q;
    assign out_bus_err    = bus_err_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_mem_stage.sv
// ============================================================================
//  Module      : tb_pipe_mem_stage
//  Description : Directed self-checking bench for pipe_mem_stage
//                (ACK_TIMEOUT = 4).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, ena, wena, sign, rd_sel, rd_wena, ack;
    logic [1:0]  dtype;
    logic [31:0] rt, alu, rdata;
    logic [4:0]  rd_waddr;
    logic        req, we, stall, wb_valid, o_rd_wena, bus_err;
    logic [3:0]  be;
    logic [31:0] addr, wdata, wb_data;
    logic [4:0]  o_rd_waddr;

    int total = 0;
    int bad   = 0;

    // Values captured during a memory transaction
    int          stalls;
    logic        cap_we;
    logic [3:0]  cap_be;
    logic [31:0] cap_addr, cap_wdata;

    always #5 clk = ~clk;

    pipe_mem_stage #(.ACK_TIMEOUT(4)) dut (
        .in_clk        (clk),
        .in_rst        (rst),
        .in_valid      (valid),
        .in_dmem_ena   (ena),
        .in_dmem_wena  (wena),
        .in_dmem_type  (dtype),
        .in_dmem_sign  (sign),
        .in_rt_data    (rt),
        .in_alu_result (alu),
        .in_rd_waddr   (rd_waddr),
        .in_rd_sel     (rd_sel),
        .in_rd_wena    (rd_wena),
        .out_dmem_req  (req),
        .out_dmem_we   (we),
        .out_dmem_be   (be),
        .out_dmem_addr (addr),
        .out_dmem_wdata(wdata),
        .in_dmem_ack   (ack),
        .in_dmem_rdata (rdata),
        .out_stall     (stall),
        .out_wb_valid  (wb_valid),
        .out_rd_wena   (o_rd_wena),
        .out_rd_waddr  (o_rd_waddr),
        .out_wb_data   (wb_data),
        .out_bus_err   (bus_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic m, input logic w, input logic [1:0] t,
                          input logic s, input logic [31:0] d,
                          input logic [31:0] a, input logic [4:0] wa,
                          input logic sel, input logic rw);
        valid = 1'b1; ena = m; wena = w; dtype = t; sign = s;
        rt = d; alu = a; rd_waddr = wa; rd_sel = sel; rd_wena = rw;
    endtask

    // Instruction already driven; counts stall cycles, captures the request
    // in the first WAIT cycle, acks after 'gap' unacknowledged WAIT cycles
    task automatic run_mem(input int gap, input logic [31:0] rd);
        stalls = 0;
        #1;
        if (stall) stalls++;
        tick;
        cap_we = we; cap_be = be; cap_addr = addr; cap_wdata = wdata;
        for (int i = 0; i < gap; i++) begin
            if (stall) stalls++;
            tick;
        end
        ack = 1'b1; rdata = rd;
        #1;
        if (stall) stalls++;
        tick;
        ack = 1'b0; valid = 1'b0; rdata = 32'd0;
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; ena = 1'b0; wena = 1'b0; dtype = 2'b00;
        sign = 1'b0; rt = 32'd0; alu = 32'd0; rd_waddr = 5'd0;
        rd_sel = 1'b0; rd_wena = 1'b0; ack = 1'b0; rdata = 32'd0;
        tick; tick;
        check_eq("rst_req",   {31'd0, req},      32'd0);
        check_eq("rst_stall", {31'd0, stall},    32'd0);
        check_eq("rst_wbv",   {31'd0, wb_valid}, 32'd0);
        check_eq("rst_be",    {28'd0, be},       32'd0);
        rst = 1'b0;
        tick;

        // ALU op: latency 1, no stall
        set_op(0, 0, 2'b00, 0, 32'd0, 32'h12345678, 5'd5, 0, 1);
        #1;
        check_eq("alu_stall", {31'd0, stall}, 32'd0);
        tick;
        valid = 1'b0;
        check_eq("alu_wbv",   {31'd0, wb_valid},  32'd1);
        check_eq("alu_data",  wb_data,            32'h12345678);
        check_eq("alu_rdw",   {31'd0, o_rd_wena}, 32'd1);
        check_eq("alu_rda",   {27'd0, o_rd_waddr}, 32'd5);
        tick;
        check_eq("idle_wbv",  {31'd0, wb_valid},  32'd0);
        check_eq("idle_rdw",  {31'd0, o_rd_wena}, 32'd0);

        // sb rt=0xAB to 0x1003, ack after 2 WAIT cycles
        set_op(1, 1, 2'b10, 0, 32'h000000AB, 32'h00001003, 5'd0, 0, 0);
        run_mem(2, 32'd0);
        check_eq("sb_be",     {28'd0, cap_be},   32'b1000);
        check_eq("sb_wdata",  cap_wdata,         32'hABABABAB);
        check_eq("sb_addr",   cap_addr,          32'h00001000);
        check_eq("sb_we",     {31'd0, cap_we},   32'd1);
        check_eq("sb_stalls", stalls,            32'd3);
        check_eq("sb_req",    {31'd0, req},      32'd0);
        check_eq("sb_rdw",    {31'd0, o_rd_wena}, 32'd0);
        check_eq("sb_wbv",    {31'd0, wb_valid},  32'd1);
        tick;

        // lb signed from 0x2001
        set_op(1, 0, 2'b10, 1, 32'd0, 32'h00002001, 5'd7, 1, 1);
        run_mem(0, 32'h0000F000);
        check_eq("lb_be",     {28'd0, cap_be},    32'b0010);
        check_eq("lb_we",     {31'd0, cap_we},    32'd0);
        check_eq("lb_data",   wb_data,            32'hFFFFFFF0);
        check_eq("lb_rdw",    {31'd0, o_rd_wena}, 32'd1);
        check_eq("lb_rda",    {27'd0, o_rd_waddr}, 32'd7);
        check_eq("lb_stalls", stalls,             32'd1);
        tick;

        // lhu from 0x2002
        set_op(1, 0, 2'b01, 0, 32'd0, 32'h00002002, 5'd8, 1, 1);
        run_mem(1, 32'h8001FFFF);
        check_eq("lhu_be",    {28'd0, cap_be},    32'b1100);
        check_eq("lhu_data",  wb_data,            32'h00008001);
        check_eq("lhu_err",   {31'd0, bus_err},   32'd0);
        tick;

        // lw from misaligned 0x3002
        set_op(1, 0, 2'b00, 0, 32'd0, 32'h00003002, 5'd9, 1, 1);
`ifdef MEM_MISALIGN_TRAP_EN
        #1;
        check_eq("mis_stall", {31'd0, stall},     32'd0);
        tick;
        valid = 1'b0;
        check_eq("mis_req",   {31'd0, req},       32'd0);
        check_eq("mis_err",   {31'd0, bus_err},   32'd1);
        check_eq("mis_rdw",   {31'd0, o_rd_wena}, 32'd0);
        check_eq("mis_wbv",   {31'd0, wb_valid},  32'd1);
        tick;
        check_eq("mis_err2",  {31'd0, bus_err},   32'd0);
`else
        run_mem(0, 32'h11223344);
        check_eq("mis_addr",  cap_addr,           32'h00003000);
        check_eq("mis_be",    {28'd0, cap_be},    32'b1111);
        check_eq("mis_data",  wb_data,            32'h11223344);
        check_eq("mis_err",   {31'd0, bus_err},   32'd0);
        tick;
`endif

        // Timeout: lw 0x4000, no ack; 4 WAIT cycles then abandoned
        set_op(1, 0, 2'b00, 0, 32'd0, 32'h00004000, 5'd3, 1, 1);
        tick;
        for (int i = 0; i < 3; i++) begin
            check_eq("to_req_wait", {31'd0, req}, 32'd1);
            tick;
        end
        check_eq("to_req_last", {31'd0, req},   32'd1);
        check_eq("to_stall",    {31'd0, stall}, 32'd0);
        tick;
        valid = 1'b0;
        check_eq("to_req",    {31'd0, req},       32'd0);
        check_eq("to_err",    {31'd0, bus_err},   32'd1);
        check_eq("to_rdw",    {31'd0, o_rd_wena}, 32'd0);
        check_eq("to_wbv",    {31'd0, wb_valid},  32'd1);
        tick;
        check_eq("to_err_pulse", {31'd0, bus_err}, 32'd0);

        // Ack in the very cycle the counter reaches the limit: ack wins
        set_op(1, 0, 2'b00, 0, 32'd0, 32'h00004004, 5'd4, 1, 1);
        tick;
        tick; tick; tick;
        ack = 1'b1; rdata = 32'hCAFEF00D;
        tick;
        ack = 1'b0; valid = 1'b0;
        check_eq("race_err",  {31'd0, bus_err},   32'd0);
        check_eq("race_rdw",  {31'd0, o_rd_wena}, 32'd1);
        check_eq("race_data", wb_data,            32'hCAFEF00D);
        tick;

        // Reset mid-WAIT
        set_op(1, 1, 2'b00, 0, 32'h55AA55AA, 32'h00005000, 5'd0, 0, 0);
        tick;
        check_eq("rw_req_on", {31'd0, req}, 32'd1);
        rst = 1'b1; valid = 1'b0;
        tick;
        check_eq("rw_req",    {31'd0, req},   32'd0);
        check_eq("rw_stall",  {31'd0, stall}, 32'd0);
        check_eq("rw_addr",   addr,           32'd0);
        check_eq("rw_wdata",  wdata,          32'd0);
        check_eq("rw_be",     {28'd0, be},    32'd0);
        rst = 1'b0; ack = 1'b1;
        tick;
        ack = 1'b0;
        check_eq("rw_late_wbv", {31'd0, wb_valid}, 32'd0);
        check_eq("rw_late_err", {31'd0, bus_err},  32'd0);
        check_eq("rw_late_req", {31'd0, req},      32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
